ram_arbiter_2p: RTL and testbench
=================================

// Module: ram_arbiter_2p
// PURPOSE
//  Two-port arbiter sharing one RAM interface block (64-bit line, 13-bit address) between two cache requesters.
//  Sits between two cache controllers and the RAM interface; all on cache_clk.
//  Round-robin grant, one outstanding transaction at a time, per-port ack and timeout error.
//  Owns the one-cycle wr/rd strobe and the ack-release handshake toward the RAM interface.
// PARAMETERS
//  AW       13    address width
//  DW       64    line data width
//  TIMEOUT  1024  cycles in WAIT before error abort (>=2)
// PORTS
//  cache_clk   in   1   single clock, all logic rising edge
//  reset_n     in   1   asynchronous active-low reset
//  p0_wr       in   1   port0 write request, level, held until p0_ack/p0_err
//  p0_rd       in   1   port0 read request, level, held until p0_ack/p0_err
//  p0_addr     in   AW  port0 line address
//  p0_wdata    in   DW  port0 write line
//  p0_rdata    out  DW  port0 read line, valid when p0_ack=1
//  p0_ack      out  1   port0 done, one-cycle pulse
//  p0_err      out  1   port0 timeout abort, one-cycle pulse
//  p1_*        --   --  identical set for port1 (p1_wr,p1_rd,p1_addr,p1_wdata,p1_rdata,p1_ack,p1_err)
//  m_wr        out  1   to RAM interface: write strobe, one cycle
//  m_rd        out  1   to RAM interface: read strobe, one cycle
//  m_addr      out  AW  to RAM interface: address, stable ISSUE..RESP
//  m_wdata     out  DW  to RAM interface: write line, stable ISSUE..RESP
//  m_rdata     in   DW  from RAM interface: read line, sampled when m_ack=1
//  m_ack       in   1   from RAM interface: completion, level (may stay high >1 cycle)
//  busy        out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, all outputs 0, last_grant=1 (port0 wins first), timer=0.
//  States: IDLE, ISSUE, WAIT, RESP, DRAIN.
//  IDLE: req_i = pi_wr|pi_rd. If one port requests, grant it; both -> grant port != last_grant.
//    On grant latch op (wr wins if pi_wr&pi_rd), addr, wdata into m_addr/m_wdata; set last_grant; -> ISSUE.
//  ISSUE: m_wr or m_rd =1 for exactly this cycle; timer=0; -> WAIT.
//  WAIT: timer+1 each cycle. m_ack=1 -> latch m_rdata (reads only) -> RESP.
//    timer==TIMEOUT-1 with m_ack=0 -> pulse pi_err for granted port -> DRAIN.
//  RESP: pi_ack=1 one cycle; pi_rdata = latched line (held until next read ack on that port);
//    -> DRAIN.
//  DRAIN: wait m_ack=0 (ack-release), then -> IDLE. No new strobe while m_ack high.
//  Latency: grant-to-strobe 1 cycle; m_ack seen cycle N -> pi_ack cycle N+1; min 4 cycles request->ack.
//  Requester drops request while in ISSUE/WAIT: transaction still completes, ack still pulsed.
//  Requester drops request before grant: ignored, no transaction.
//  Request still high in cycle after own ack: treated as new request (requester must drop in ack cycle).
//  Both ports request continuously: strict alternation 0,1,0,1...
//  m_ack high while IDLE/ISSUE (spurious): ignored; ISSUE still proceeds, WAIT needs fresh sample.
//  reset_n low mid-transaction: immediate abort, no ack/err emitted, m_wr/m_rd forced 0.
//  timer width = clog2(TIMEOUT)+1; no wrap before TIMEOUT.
//  Non-granted port ack/err/rdata never change.
// TESTING
//  p0_rd, addr=0x0A5 alone -> m_rd one pulse, m_addr=0x0A5; m_ack after 10 cyc, m_rdata=0x1122334455667788 -> p0_ack pulse, p0_rdata=0x1122334455667788.
//  p0_wr and p1_wr same cycle from reset -> port0 first, then port1; m_wdata matches each; one ack per port.
//  Both ports hold rd for 4 transactions -> grant order 0,1,0,1; p1_rdata unchanged during port0 acks.
//  m_ack held high 5 cycles -> single pi_ack; next m_rd only after m_ack falls.
//  TIMEOUT=16, m_ack never asserts -> p1_err pulse 16 cycles after ISSUE, no p1_ack, returns IDLE.
//  reset_n low during WAIT -> all outputs 0 immediately; after release, pending p0_rd re-issued fresh.

Source files
------------

// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter sharing one RAM interface between two cache ports.
// Ports: p0_*/p1_* requester sides, m_* RAM side, busy status; cache_clk domain.
module ram_arbiter_2p #(
    parameter int AW      = 13,
    parameter int DW      = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic          cache_clk,
    input  logic          reset_n,
    input  logic          p0_wr,
    input  logic          p0_rd,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_ack,
    output logic          p0_err,
    input  logic          p1_wr,
    input  logic          p1_rd,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_ack,
    output logic          p1_err,
    output logic          m_wr,
    output logic          m_rd,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          busy
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, RESP, DRAIN
    } state_t;

    state_t        state;
    logic          last_grant;
    logic          grant;
    logic          op_wr;
    logic [TW-1:0] timer;

    logic req0, req1, pick, sel_wr;

    assign req0 = p0_wr | p0_rd;
    assign req1 = p1_wr | p1_rd;
    // pick = 1 selects port1; ties go to the port not served last
    assign pick = (req0 & req1) ? ~last_grant : req1;
    assign sel_wr = pick ? p1_wr : p0_wr;
    assign busy = (state != IDLE);

    always_ff @(posedge cache_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            op_wr      <= 1'b0;
            timer      <= '0;
            m_wr       <= 1'b0;
            m_rd       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_err     <= 1'b0;
            p1_err     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        grant      <= pick;
                        last_grant <= pick;
                        op_wr      <= sel_wr;
                        m_wr       <= sel_wr;
                        m_rd       <= ~sel_wr;
                        m_addr     <= pick ? p1_addr : p0_addr;
                        m_wdata    <= pick ? p1_wdata : p0_wdata;
                        timer      <= '0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // strobe lasts exactly the ISSUE cycle; timer
                    // counts from ISSUE so the abort lands TIMEOUT
                    // cycles after the strobe
                    m_wr  <= 1'b0;
                    m_rd  <= 1'b0;
                    timer <= timer + 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (m_ack) begin
                        if (!op_wr) begin
                            if (grant) p1_rdata <= m_rdata;
                            else       p0_rdata <= m_rdata;
                        end
                        if (grant) p1_ack <= 1'b1;
                        else       p0_ack <= 1'b1;
                        state <= RESP;
                    end else if (timer == T_LAST) begin
                        if (grant) p1_err <= 1'b1;
                        else       p0_err <= 1'b1;
                        state <= DRAIN;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    state  <= DRAIN;
                end
                DRAIN: begin
                    p0_err <= 1'b0;
                    p1_err <= 1'b0;
                    // hold off until the RAM side releases its ack
                    if (!m_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed self-checking bench for ram_arbiter_2p.
// Instance uses TIMEOUT=16 so the abort path is reachable quickly.
module tb_ram_arbiter_2p;
    localparam int AW = 13;
    localparam int DW = 64;

    logic          cache_clk;
    logic          reset_n;
    logic          p0_wr, p0_rd, p1_wr, p1_rd;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          p0_ack, p0_err, p1_ack, p1_err;
    logic          m_wr, m_rd, m_ack, busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    int n_chk = 0;
    int n_fail = 0;

    ram_arbiter_2p #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
        .cache_clk(cache_clk), .reset_n(reset_n),
        .p0_wr(p0_wr), .p0_rd(p0_rd), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rdata(p0_rdata),
        .p0_ack(p0_ack), .p0_err(p0_err),
        .p1_wr(p1_wr), .p1_rd(p1_rd), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rdata(p1_rdata),
        .p1_ack(p1_ack), .p1_err(p1_err),
        .m_wr(m_wr), .m_rd(m_rd), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata),
        .m_ack(m_ack), .busy(busy)
    );

    initial cache_clk = 1'b0;
    always #5 cache_clk = ~cache_clk;

    task automatic tick();
        @(posedge cache_clk);
        #1;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_rd | m_wr) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        p0_wr = 0; p0_rd = 0; p1_wr = 0; p1_rd = 0;
        p0_addr = '0; p1_addr = '0;
        p0_wdata = '0; p1_wdata = '0;
        m_ack = 0; m_rdata = '0;
        repeat (2) @(posedge cache_clk);
        #1;
        n_chk++;
        if ({m_wr, m_rd, busy, p0_ack, p1_ack, p0_err, p1_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {m_wr, m_rd, busy, p0_ack, p1_ack, p0_err, p1_err});
        end
        n_chk++;
        if (m_addr !== '0 || m_wdata !== '0 || p0_rdata !== '0 || p1_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr %h wdata %h r0 %h r1 %h want 0",
                     m_addr, m_wdata, p0_rdata, p1_rdata);
        end
        reset_n = 1'b1;
        tick();
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy %b want 0", busy);
        end
    endtask

    task automatic test_single_read();
        bit seen;
        p0_rd = 1; p0_addr = 13'h0A5;
        tick();
        n_chk++;
        if (m_rd !== 1'b1 || m_wr !== 1'b0 || m_addr !== 13'h0A5 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_issue: rd %b wr %b addr %h busy %b want 1 0 0a5 1",
                     m_rd, m_wr, m_addr, busy);
        end
        seen = 0;
        repeat (10) begin
            tick();
            seen = seen | m_rd | m_wr | p0_ack | p0_err;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_single_pulse: extra activity %b want 0", seen);
        end
        m_ack = 1; m_rdata = 64'h1122334455667788;
        tick();
        n_chk++;
        if (p0_ack !== 1'b1 || p0_rdata !== 64'h1122334455667788 || p1_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_ack: ack %b rdata %h p1_ack %b want 1 1122334455667788 0",
                     p0_ack, p0_rdata, p1_ack);
        end
        p0_rd = 0; m_ack = 0; m_rdata = '0;
        tick();
        n_chk++;
        if (p0_ack !== 1'b0 || p0_rdata !== 64'h1122334455667788) begin
            n_fail++;
            $display("FAIL rd_ack_pulse: ack %b rdata %h want 0 1122334455667788",
                     p0_ack, p0_rdata);
        end
        tick();
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_done_idle: busy %b want 0", busy);
        end
    endtask

    task automatic test_simultaneous_write();
        reset_n = 0;
        #3;
        reset_n = 1;
        p0_wr = 1; p0_addr = 13'h100; p0_wdata = 64'hAAAA_5555_0000_0001;
        p1_wr = 1; p1_addr = 13'h1FFF; p1_wdata = 64'hBBBB_6666_0000_0002;
        tick();
        n_chk++;
        if (m_wr !== 1'b1 || m_rd !== 1'b0 || m_addr !== 13'h100 ||
            m_wdata !== 64'hAAAA_5555_0000_0001) begin
            n_fail++;
            $display("FAIL wr0_issue: wr %b rd %b addr %h wdata %h want 1 0 100 aaaa555500000001",
                     m_wr, m_rd, m_addr, m_wdata);
        end
        tick();
        m_ack = 1;
        tick();
        n_chk++;
        if (p0_ack !== 1'b1 || p1_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wr0_ack: p0 %b p1 %b want 1 0", p0_ack, p1_ack);
        end
        p0_wr = 0; m_ack = 0;
        tick();
        tick();
        tick();
        n_chk++;
        if (m_wr !== 1'b1 || m_addr !== 13'h1FFF ||
            m_wdata !== 64'hBBBB_6666_0000_0002) begin
            n_fail++;
            $display("FAIL wr1_issue: wr %b addr %h wdata %h want 1 1fff bbbb666600000002",
                     m_wr, m_addr, m_wdata);
        end
        tick();
        m_ack = 1;
        tick();
        n_chk++;
        if (p1_ack !== 1'b1 || p0_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wr1_ack: p1 %b p0 %b want 1 0", p1_ack, p0_ack);
        end
        p1_wr = 0; m_ack = 0;
        tick();
        tick();
        n_chk++;
        if (busy !== 1'b0 || p0_rdata !== 64'h0 || p1_rdata !== 64'h0) begin
            n_fail++;
            $display("FAIL wr_done: busy %b r0 %h r1 %h want 0 0 0",
                     busy, p0_rdata, p1_rdata);
        end
    endtask

    task automatic test_alternation();
        bit ok;
        int exp;
        logic [DW-1:0] old0, old1, d;
        p0_rd = 1; p0_addr = 13'h010;
        p1_rd = 1; p1_addr = 13'h020;
        for (int k = 0; k < 4; k++) begin
            exp = k % 2;
            wait_strobe(ok);
            n_chk++;
            if (!ok || m_addr !== (exp == 1 ? 13'h020 : 13'h010)) begin
                n_fail++;
                $display("FAIL alt_grant%0d: strobe %b addr %h want 1 port%0d", k, ok, m_addr, exp);
            end
            old0 = p0_rdata; old1 = p1_rdata;
            d = 64'hA000_0000_0000_0000 + 64'(k);
            tick();
            m_ack = 1; m_rdata = d;
            tick();
            n_chk++;
            if ((exp == 1 ? {p1_ack, p0_ack} : {p0_ack, p1_ack}) !== 2'b10) begin
                n_fail++;
                $display("FAIL alt_ack%0d: p0 %b p1 %b want port%0d only", k, p0_ack, p1_ack, exp);
            end
            n_chk++;
            if ((exp == 1 ? p1_rdata : p0_rdata) !== d ||
                (exp == 1 ? p0_rdata : p1_rdata) !== (exp == 1 ? old0 : old1)) begin
                n_fail++;
                $display("FAIL alt_rdata%0d: r0 %h r1 %h want port%0d=%h other unchanged",
                         k, p0_rdata, p1_rdata, exp, d);
            end
            m_ack = 0;
            if (k == 3) begin
                p0_rd = 0; p1_rd = 0;
            end
        end
        tick();
        tick();
        tick();
        n_chk++;
        if (busy !== 1'b0 || m_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL alt_done: busy %b rd %b want 0 0", busy, m_rd);
        end
    endtask

    task automatic test_ack_hold();
        bit ok;
        int acks;
        bit early;
        p0_rd = 1; p0_addr = 13'h033;
        wait_strobe(ok);
        tick();
        m_ack = 1; m_rdata = 64'hCAFE_F00D_1234_5678;
        acks = 0; early = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acks += int'(p0_ack);
            early = early | m_rd | m_wr;
            if (i == 0) begin
                p0_rd = 0; p1_rd = 1; p1_addr = 13'h044;
            end
        end
        m_ack = 0;
        n_chk++;
        if (!ok || acks != 1 || p0_rdata !== 64'hCAFE_F00D_1234_5678) begin
            n_fail++;
            $display("FAIL hold_single_ack: strobe %b acks %0d rdata %h want 1 1 cafef00d12345678",
                     ok, acks, p0_rdata);
        end
        n_chk++;
        if (early !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_no_strobe: strobe while ack high %b want 0", early);
        end
        tick();
        n_chk++;
        if (m_rd !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: rd %b busy %b want 0 0", m_rd, busy);
        end
        tick();
        n_chk++;
        if (m_rd !== 1'b1 || m_addr !== 13'h044) begin
            n_fail++;
            $display("FAIL hold_next_issue: rd %b addr %h want 1 044", m_rd, m_addr);
        end
        tick();
        m_ack = 1; m_rdata = 64'h0F0F_0F0F_0F0F_0F0F;
        tick();
        n_chk++;
        if (p1_ack !== 1'b1 || p1_rdata !== 64'h0F0F_0F0F_0F0F_0F0F) begin
            n_fail++;
            $display("FAIL hold_p1_ack: ack %b rdata %h want 1 0f0f0f0f0f0f0f0f", p1_ack, p1_rdata);
        end
        p1_rd = 0; m_ack = 0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        bit bad;
        p1_rd = 1; p1_addr = 13'h077;
        wait_strobe(ok);
        n = 0; bad = 0;
        while (n < 40 && p1_err !== 1'b1) begin
            tick();
            n++;
            bad = bad | p1_ack | p0_ack | p0_err;
        end
        p1_rd = 0;
        n_chk++;
        if (!ok || n != 16) begin
            n_fail++;
            $display("FAIL to_latency: strobe %b err after %0d cycles want 16", ok, n);
        end
        n_chk++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL to_no_ack: stray ack/err %b want 0", bad);
        end
        tick();
        n_chk++;
        if (p1_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_idle: err %b busy %b want 0 0", p1_err, busy);
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        p0_rd = 1; p0_addr = 13'h055;
        wait_strobe(ok);
        tick();
        tick();
        tick();
        reset_n = 0;
        #1;
        n_chk++;
        if (!ok || {m_wr, m_rd, busy, p0_ack, p0_err, p1_ack, p1_err} !== 7'b0 ||
            m_addr !== '0 || p0_rdata !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: strobe %b ctrl %b addr %h r0 %h want 1 0 0 0",
                     ok, {m_wr, m_rd, busy, p0_ack, p0_err, p1_ack, p1_err}, m_addr, p0_rdata);
        end
        #2;
        reset_n = 1;
        tick();
        n_chk++;
        if (m_rd !== 1'b1 || m_addr !== 13'h055) begin
            n_fail++;
            $display("FAIL abort_reissue: rd %b addr %h want 1 055", m_rd, m_addr);
        end
        tick();
        m_ack = 1; m_rdata = 64'h5555_AAAA_5555_AAAA;
        tick();
        n_chk++;
        if (p0_ack !== 1'b1 || p0_rdata !== 64'h5555_AAAA_5555_AAAA) begin
            n_fail++;
            $display("FAIL abort_complete: ack %b rdata %h want 1 5555aaaa5555aaaa", p0_ack, p0_rdata);
        end
        p0_rd = 0; m_ack = 0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous_write();
        test_alternation();
        test_ack_hold();
        test_timeout();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
